ram_dp_be: RTL and testbench

Parametrised simple dual-port RAM with one write port and one read port. Successor to the fixed 16x8 RAM, adding:
- configurable width and depth
- per-byte write enables
- selectable read latency
- defined read-during-write behaviour
- hardware zero-initialisation sequence after reset

Sits as the storage element under the layered RAM testbench. It is the drop-in target for multi-case verification.

---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_rd_pipe.sv | 25 ++
 rtl/ram_dp_be.sv | 136 +++++++++++++
 tb/tb_ram_dp_be.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: FSM states,
// default parameter values and the byte-lane width helper.
package ram_pkg;

  // INIT sweeps zeros through the array; READY serves the two ports.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_RD_LATENCY  = 1;
  localparam int DEF_WRITE_FIRST = 0;
  localparam int DEF_BE_WIDTH    = DEF_DATA_WIDTH / 8;

  // Number of byte lanes in a word of the given width.
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Optional second read stage: delays read data and valid by one cycle.
// Data is only loaded on a valid beat so the output holds between reads.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Register stage; reset drops any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM (one write port, one read port) with byte enables,
// 1- or 2-cycle read latency, selectable read-during-write policy and a
// zero-fill sweep after every reset.
//
// Port protocol: there is no back-pressure. In READY every cycle with
// wr_en high is a write and every cycle with rd_en high is a read; each
// read yields exactly one rd_valid pulse RD_LATENCY cycles later unless a
// reset intervenes. During INIT both requests are dropped silently.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int RD_LATENCY  = DEF_RD_LATENCY,
  parameter int WRITE_FIRST = DEF_WRITE_FIRST
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    addr_err
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH);
  // One extra counter bit so DEPTH == 2**ADDR_WIDTH needs no wrap logic.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  wr_ok, rd_ok;
  logic                  wr_go, rd_go;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  err_q;

  assign ready     = (state_q == READY);
  assign init_busy = (state_q == INIT);
  assign wr_ok     = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok     = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_go     = ready && wr_en && wr_ok;
  assign rd_go     = ready && rd_en;
  assign addr_err  = err_q;

  // Next-state: leave INIT once the last word is being cleared.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (cnt_q == LAST_W) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // State register and sweep counter; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) cnt_q <= cnt_q + (ADDR_WIDTH + 1)'(1);
    end
  end

  // Storage: zero-fill during INIT, byte-merged writes in READY.
  // The array itself is untouched on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_go) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read word: zero out of range, optional bypass of enabled write bytes.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[rd_addr];
      if ((WRITE_FIRST != 0) && wr_go && (wr_addr == rd_addr)) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // First read stage and the shared out-of-range flag (one pulse per cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) s1_data <= rd_word;
      err_q <= ready && ((wr_en && !wr_ok) || (rd_en && !rd_ok));
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      ram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s1_valid),
        .in_data  (s1_data),
        .out_valid(rd_valid),
        .out_data (rd_data)
      );
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be. Two instances share one stimulus stream:
//   a: 32-bit, DEPTH=12, RD_LATENCY=1, WRITE_FIRST=0
//   b: 32-bit, DEPTH=16, RD_LATENCY=2, WRITE_FIRST=1
// A behavioural model (word arrays plus queues of expected read results
// tagged with the cycle they are due) predicts both.
module tb_ram_dp_be;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic        busy_a, busy_b, valid_a, valid_b, err_a, err_b;
  logic [31:0] data_a, data_b;

  logic [1:0]       obs_busy, obs_valid, obs_err;
  logic [1:0][31:0] obs_data;
  assign obs_busy  = {busy_b, busy_a};
  assign obs_valid = {valid_b, valid_a};
  assign obs_err   = {err_b, err_a};
  assign obs_data  = {data_b, data_a};

  ram_dp_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(1), .WRITE_FIRST(0)
  ) dut_a (
    .clk(clk), .rst(rst), .init_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(data_a), .rd_valid(valid_a), .addr_err(err_a)
  );

  ram_dp_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(2), .WRITE_FIRST(1)
  ) dut_b (
    .clk(clk), .rst(rst), .init_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(data_b), .rd_valid(valid_b), .addr_err(err_b)
  );

  // ---------------- reference model ----------------
  int          depth_m [2] = '{12, 16};
  int          lat_m   [2] = '{1, 2};
  bit          wf_m    [2] = '{1'b0, 1'b1};
  logic [31:0] mem_m   [2][16];
  int          init_left [2];

  logic [31:0] exp_q_a[$], exp_q_b[$];
  int          due_q_a[$], due_q_b[$];

  logic [1:0]       exp_busy, exp_valid, exp_err;
  logic [1:0][31:0] exp_data;

  int cyc;
  int pass_cnt;
  int total_cnt;

  // Apply the effect of the coming edge to the model, using current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] word;
      bit wr_ok, rd_ok;
      exp_err[i] = 1'b0;
      if (rst) begin
        init_left[i] = depth_m[i];
        exp_data[i]  = '0;
        if (i == 0) begin exp_q_a.delete(); due_q_a.delete(); end
        else        begin exp_q_b.delete(); due_q_b.delete(); end
      end else if (init_left[i] > 0) begin
        init_left[i]--;
        if (init_left[i] == 0)
          for (int a = 0; a < 16; a++) mem_m[i][a] = '0;
      end else begin
        wr_ok = int'(wr_addr) < depth_m[i];
        rd_ok = int'(rd_addr) < depth_m[i];
        exp_err[i] = (wr_en && !wr_ok) || (rd_en && !rd_ok);
        if (rd_en) begin
          word = rd_ok ? mem_m[i][rd_addr] : 32'h0;
          if (rd_ok && wf_m[i] && wr_en && wr_ok && wr_addr == rd_addr)
            for (int b = 0; b < 4; b++)
              if (wr_be[b]) word[8*b +: 8] = wr_data[8*b +: 8];
          if (i == 0) begin exp_q_a.push_back(word); due_q_a.push_back(cyc + lat_m[i] - 1); end
          else        begin exp_q_b.push_back(word); due_q_b.push_back(cyc + lat_m[i] - 1); end
        end
        if (wr_en && wr_ok)
          for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem_m[i][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      end
      exp_busy[i] = (init_left[i] != 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic drive_wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
  endtask

  task automatic drive_rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  // One clock: update model, pass the edge, settle, retire due reads.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    exp_valid = '0;
    if (due_q_a.size() > 0 && due_q_a[0] == cyc) begin
      exp_valid[0] = 1'b1; exp_data[0] = exp_q_a.pop_front(); void'(due_q_a.pop_front());
    end
    if (due_q_b.size() > 0 && due_q_b[0] == cyc) begin
      exp_valid[1] = 1'b1; exp_data[1] = exp_q_b.pop_front(); void'(due_q_b.pop_front());
    end
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (obs_busy[i] !== 1'b1 || obs_valid[i] !== 1'b0 || obs_data[i] !== 32'h0 || obs_err[i] !== 1'b0)
        $display("FAIL reset_state[%0d] got busy=%b valid=%b data=%h err=%b exp busy=1 valid=0 data=0 err=0",
                 i, obs_busy[i], obs_valid[i], obs_data[i], obs_err[i]);
      else pass_cnt++;
    end
    rst = 1'b0;
    // Requests during the sweep must be ignored.
    for (int n = 1; n <= 16; n++) begin
      drive_idle();
      if (n <= 12) begin
        drive_wr(4'($urandom_range(0, 15)), 4'hF, $urandom);
        drive_rd(4'($urandom_range(0, 15)));
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if (obs_busy[i] !== exp_busy[i] || obs_busy[i] !== (n < depth_m[i]))
          $display("FAIL init_busy[%0d] n=%0d got=%b exp=%b", i, n, obs_busy[i], (n < depth_m[i]));
        else pass_cnt++;
        total_cnt++;
        if (obs_valid[i] !== 1'b0 || obs_err[i] !== 1'b0)
          $display("FAIL init_ignore[%0d] n=%0d got valid=%b err=%b exp 0 0", i, n, obs_valid[i], obs_err[i]);
        else pass_cnt++;
      end
    end
    // Every word reads back as zero.
    for (int a = 0; a <= 16; a++) begin
      drive_idle();
      if (a < 16) drive_rd(4'(a));
      tick();
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if (obs_valid[i] !== exp_valid[i] || (exp_valid[i] && obs_data[i] !== 32'h0))
          $display("FAIL zero_read[%0d] a=%0d got valid=%b data=%h exp valid=%b data=0",
                   i, a, obs_valid[i], obs_data[i], exp_valid[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_err[0] !== (a >= 12 && a < 16))
        $display("FAIL zero_read_err a=%0d got=%b exp=%b", a, obs_err[0], (a >= 12 && a < 16));
      else pass_cnt++;
    end
  endtask

  task automatic test_byte_enable();
    drive_idle(); drive_wr(4'd3, 4'hF, 32'hAABBCCDD); tick();
    drive_idle(); drive_wr(4'd3, 4'h5, 32'h11223344); tick();
    drive_idle(); drive_rd(4'd3); tick();
    total_cnt++;
    if (obs_valid[0] !== 1'b1 || obs_data[0] !== 32'hAA22CC44)
      $display("FAIL byte_en_a got valid=%b data=%h exp valid=1 data=aa22cc44", obs_valid[0], obs_data[0]);
    else pass_cnt++;
    drive_idle(); tick();
    total_cnt++;
    if (obs_valid[1] !== 1'b1 || obs_data[1] !== 32'hAA22CC44)
      $display("FAIL byte_en_b got valid=%b data=%h exp valid=1 data=aa22cc44", obs_valid[1], obs_data[1]);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    drive_idle(); drive_wr(4'd5, 4'hF, 32'h12); tick();
    drive_idle(); drive_wr(4'd5, 4'hF, 32'h34); drive_rd(4'd5); tick();
    total_cnt++;
    if (obs_valid[0] !== 1'b1 || obs_data[0] !== 32'h12)
      $display("FAIL collision_read_first got valid=%b data=%h exp valid=1 data=12", obs_valid[0], obs_data[0]);
    else pass_cnt++;
    drive_idle(); tick();
    total_cnt++;
    if (obs_valid[1] !== 1'b1 || obs_data[1] !== 32'h34)
      $display("FAIL collision_write_first got valid=%b data=%h exp valid=1 data=34", obs_valid[1], obs_data[1]);
    else pass_cnt++;
    // Write now visible to a following read on both policies.
    drive_idle(); drive_rd(4'd5); tick(); drive_idle(); tick();
    total_cnt++;
    if (obs_data[0] !== 32'h34 || obs_data[1] !== 32'h34)
      $display("FAIL collision_after got a=%h b=%h exp 34 34", obs_data[0], obs_data[1]);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    logic [31:0] base;
    base = 32'hC0DE0000;
    for (int a = 0; a < 3; a++) begin
      drive_idle(); drive_wr(4'(a), 4'hF, base + 32'(a)); tick();
    end
    for (int t = 0; t < 5; t++) begin
      drive_idle();
      if (t < 3) drive_rd(4'(t));
      tick();
      total_cnt++;
      if (obs_valid[0] !== (t < 3) || (t < 3 && obs_data[0] !== base + 32'(t)))
        $display("FAIL latency1 t=%0d got valid=%b data=%h exp valid=%b data=%h",
                 t, obs_valid[0], obs_data[0], (t < 3), base + 32'(t));
      else pass_cnt++;
      total_cnt++;
      if (obs_valid[1] !== (t >= 1 && t <= 3) || (t >= 1 && t <= 3 && obs_data[1] !== base + 32'(t - 1)))
        $display("FAIL latency2 t=%0d got valid=%b data=%h exp valid=%b data=%h",
                 t, obs_valid[1], obs_data[1], (t >= 1 && t <= 3), base + 32'(t - 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_range();
    drive_idle(); drive_wr(4'd13, 4'hF, 32'hFF); tick();
    total_cnt++;
    if (obs_err[0] !== 1'b1 || obs_err[1] !== 1'b0)
      $display("FAIL range_wr_err got a=%b b=%b exp a=1 b=0", obs_err[0], obs_err[1]);
    else pass_cnt++;
    drive_idle(); tick();
    total_cnt++;
    if (obs_err[0] !== 1'b0)
      $display("FAIL range_err_pulse got=%b exp=0", obs_err[0]);
    else pass_cnt++;
    drive_idle(); drive_rd(4'd13); tick();
    total_cnt++;
    if (obs_valid[0] !== 1'b1 || obs_data[0] !== 32'h0 || obs_err[0] !== 1'b1)
      $display("FAIL range_rd got valid=%b data=%h err=%b exp valid=1 data=0 err=1",
               obs_valid[0], obs_data[0], obs_err[0]);
    else pass_cnt++;
    drive_idle(); tick();
    total_cnt++;
    if (obs_valid[1] !== 1'b1 || obs_data[1] !== 32'hFF || obs_err[1] !== 1'b0)
      $display("FAIL range_in_b got valid=%b data=%h err=%b exp valid=1 data=ff err=0",
               obs_valid[1], obs_data[1], obs_err[1]);
    else pass_cnt++;
    drive_idle(); drive_wr(4'd14, 4'hF, 32'h55); drive_rd(4'd15); tick();
    total_cnt++;
    if (obs_err[0] !== 1'b1)
      $display("FAIL range_both got=%b exp=1", obs_err[0]);
    else pass_cnt++;
    drive_idle(); tick();
    total_cnt++;
    if (obs_err[0] !== 1'b0)
      $display("FAIL range_both_single got=%b exp=0", obs_err[0]);
    else pass_cnt++;
    drive_idle(); tick();
  endtask

  task automatic test_mid_reset();
    int  fall_at [2];
    bit  done [2];
    drive_idle();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 7; n++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    fall_at = '{0, 0};
    done = '{1'b0, 1'b0};
    for (int n = 1; n <= 40; n++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (!done[i] && !obs_busy[i]) begin done[i] = 1'b1; fall_at[i] = n; end
      if (done[0] && done[1]) break;
    end
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (fall_at[i] != depth_m[i])
        $display("FAIL restart_len[%0d] got=%0d exp=%0d", i, fall_at[i], depth_m[i]);
      else pass_cnt++;
    end
    // Read in flight on the 2-cycle instance, then reset over it.
    drive_idle(); drive_rd(4'd2); tick();
    drive_idle(); rst = 1'b1; tick(); rst = 1'b0;
    total_cnt++;
    if (obs_valid[1] !== 1'b0 || obs_data[1] !== 32'h0)
      $display("FAIL flush_rd got valid=%b data=%h exp valid=0 data=0", obs_valid[1], obs_data[1]);
    else pass_cnt++;
    for (int n = 0; n < 17; n++) begin
      tick();
      total_cnt++;
      if (obs_valid !== 2'b00)
        $display("FAIL flush_quiet n=%0d got=%b exp=00", n, obs_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive_idle();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1)) drive_wr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 2) != 0) drive_rd(4'($urandom_range(0, 15)));
      // Bias toward same-address collisions.
      if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
      tick();
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if (obs_busy[i] !== exp_busy[i] || obs_valid[i] !== exp_valid[i] ||
            obs_err[i] !== exp_err[i] || obs_data[i] !== exp_data[i])
          $display("FAIL random[%0d] n=%0d got busy=%b valid=%b err=%b data=%h exp busy=%b valid=%b err=%b data=%h",
                   i, n, obs_busy[i], obs_valid[i], obs_err[i], obs_data[i],
                   exp_busy[i], exp_valid[i], exp_err[i], exp_data[i]);
        else pass_cnt++;
      end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cyc = 0; pass_cnt = 0; total_cnt = 0;
    exp_busy = '0; exp_valid = '0; exp_err = '0; exp_data = '0;
    init_left = '{0, 0};
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_byte_enable();
    test_collision();
    test_latency();
    test_range();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
